// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder block: default operand width and the
// reset values of every register in the registered path.
package full_adder_pkg;

    localparam int   WIDTH_DEFAULT = 1;

    localparam logic SUM_RST_BIT   = 1'b0;
    localparam logic COUT_RST      = 1'b0;
    localparam logic VLD_RST       = 1'b0;
    localparam logic CY_RST        = 1'b0;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell, the leaf of both ripple chains.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry full adder with a combinational result, a registered result
// with valid tracking, and a bit-serial carry-feedback mode for LSB-first words.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] Y1,
    output logic             Y2,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             ser_en,
    input  logic             ser_clr,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_vld
);

    logic [WIDTH:0]   comb_c_s;
    logic [WIDTH:0]   reg_c_s;
    logic [WIDTH-1:0] reg_sum_s;
    logic             cin_r_s;
    logic             cy_r;

    assign comb_c_s[0] = C;
    assign Y2          = comb_c_s[WIDTH];
    assign reg_c_s[0]  = cin_r_s;

    // Two independent chains: the combinational one never sees clk or rst.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_comb (
            .a  (A[i]),
            .b  (B[i]),
            .ci (comb_c_s[i]),
            .s  (Y1[i]),
            .co (comb_c_s[i+1])
        );

        fa_cell u_reg (
            .a  (A[i]),
            .b  (B[i]),
            .ci (reg_c_s[i]),
            .s  (reg_sum_s[i]),
            .co (reg_c_s[i+1])
        );
    end

    // Carry-in select for the registered chain; ser_clr starts a new serial word.
    always_comb begin
        cin_r_s = C;
        if (ser_en) begin
            if (ser_clr) begin
                cin_r_s = 1'b0;
            end else begin
                cin_r_s = cy_r;
            end
        end else begin
            cin_r_s = C;
        end
    end

    // Registered result, serial carry and valid tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= {WIDTH{SUM_RST_BIT}};
            cout_q  <= COUT_RST;
            out_vld <= VLD_RST;
            cy_r    <= CY_RST;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                sum_q  <= reg_sum_s;
                cout_q <= reg_c_s[WIDTH];
                cy_r   <= reg_c_s[WIDTH];
            end else if (ser_clr) begin
                cy_r   <= 1'b0;
            end else begin
                cy_r   <= cy_r;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;

    logic clk;
    logic rst;

    logic       a1, b1, c1, vld1, sen1, sclr1;
    logic       y1_1, y2_1, sum1, cout1, ovld1;

    logic [3:0] a4, b4, sum4, y1_4;
    logic       c4, vld4, y2_4, cout4, ovld4;

    int checks;
    int failures;

    full_adder #(.WIDTH(1)) dut1 (
        .Y1(y1_1), .Y2(y2_1), .A(a1), .B(b1), .C(c1),
        .clk(clk), .rst(rst), .in_vld(vld1), .ser_en(sen1), .ser_clr(sclr1),
        .sum_q(sum1), .cout_q(cout1), .out_vld(ovld1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .Y1(y1_4), .Y2(y2_4), .A(a4), .B(b4), .C(c4),
        .clk(clk), .rst(rst), .in_vld(vld4), .ser_en(1'b0), .ser_clr(1'b0),
        .sum_q(sum4), .cout_q(cout4), .out_vld(ovld4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ABC combos in test-plan order with expected {Y2,Y1}
    logic [2:0] combo_in  [8];
    logic [1:0] combo_exp [8];

    initial begin
        logic [4:0] exp5;
        checks   = 0;
        failures = 0;
        combo_in  = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};
        combo_exp = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; vld1 = 1'b0; sen1 = 1'b0; sclr1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0; vld4 = 1'b0;

        #12;
        check("rst_sum1",  {7'd0, sum1},  8'd0);
        check("rst_cout1", {7'd0, cout1}, 8'd0);
        check("rst_vld1",  {7'd0, ovld1}, 8'd0);
        check("rst_sum4",  {4'd0, sum4},  8'd0);
        check("rst_vld4",  {7'd0, ovld4}, 8'd0);
        a1 = 1'b1;
        #1;
        check("rst_y1_comb", {7'd0, y1_1}, 8'd1);
        a1 = 1'b0;

        tick;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a1 = combo_in[i][2]; b1 = combo_in[i][1]; c1 = combo_in[i][0];
            #1;
            check($sformatf("combo_%0d%0d%0d", a1, b1, c1), {6'd0, y2_1, y1_1}, {6'd0, combo_exp[i]});
        end

        // Registered path: 1+1+0
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; vld1 = 1'b1;
        tick;
        check("reg_sum",  {7'd0, sum1},  8'd0);
        check("reg_cout", {7'd0, cout1}, 8'd1);
        check("reg_vld",  {7'd0, ovld1}, 8'd1);
        vld1 = 1'b0; a1 = 1'b0;
        tick;
        check("hold_vld",  {7'd0, ovld1}, 8'd0);
        check("hold_sum",  {7'd0, sum1},  8'd0);
        check("hold_cout", {7'd0, cout1}, 8'd1);

        // Serial 3+3 LSB-first; C is driven to values the serial path must ignore
        sen1 = 1'b1; sclr1 = 1'b1; vld1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        tick;
        check("ser_bit0",  {7'd0, sum1},  8'd0);
        check("ser_cy0",   {7'd0, cout1}, 8'd1);
        sclr1 = 1'b0; c1 = 1'b0;
        tick;
        check("ser_bit1",  {7'd0, sum1},  8'd1);
        check("ser_cout",  {7'd0, cout1}, 8'd1);

        // ser_clr with in_vld=0 clears the carry but holds outputs
        vld1 = 1'b0; sclr1 = 1'b1;
        tick;
        check("clr_hold_sum", {7'd0, sum1}, 8'd1);
        sclr1 = 1'b0; vld1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        tick;
        check("clr_cy_sum", {7'd0, sum1}, 8'd0);

        // ser_en dropped mid-word: C takes over
        sen1 = 1'b0; c1 = 1'b1;
        tick;
        check("ser_off_sum",  {7'd0, sum1},  8'd1);
        check("ser_off_cout", {7'd0, cout1}, 8'd0);

        // Load sum=1, carry=1, then async reset between edges
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        tick;
        check("load_sum", {7'd0, sum1}, 8'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sum",  {7'd0, sum1},  8'd0);
        check("arst_cout", {7'd0, cout1}, 8'd0);
        check("arst_vld",  {7'd0, ovld1}, 8'd0);
        check("arst_comb", {6'd0, y2_1, y1_1}, 8'd3);
        a1 = 1'b0; c1 = 1'b0;
        #1;
        check("arst_comb2", {6'd0, y2_1, y1_1}, 8'd1);
        tick;
        check("arst_hold_sum", {7'd0, sum1},  8'd0);
        check("arst_hold_vld", {7'd0, ovld1}, 8'd0);
        #1;
        rst = 1'b0;
        sen1 = 1'b1; sclr1 = 1'b0; vld1 = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
        tick;
        check("arst_cy_clr", {7'd0, sum1}, 8'd0);
        vld1 = 1'b0; sen1 = 1'b0;

        // WIDTH=4 exhaustive
        vld4 = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); c4 = 1'(ic);
                    exp5 = 5'(ia + ib + ic);
                    #1;
                    check($sformatf("w4_comb_%0d_%0d_%0d", ia, ib, ic), {3'd0, y2_4, y1_4}, {3'd0, exp5});
                    tick;
                    check($sformatf("w4_reg_%0d_%0d_%0d", ia, ib, ic), {3'd0, cout4, sum4}, {3'd0, exp5});
                end
            end
        end
        check("w4_vld", {7'd0, ovld4}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
